// File: rtl/prog_seq_pkg.sv
// Shared state type and default configuration constants for prog_sequencer
// and its return stack.
package prog_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StRun,
    StHalted
  } seq_state_e;

  localparam int unsigned DefA     = 10;
  localparam int unsigned DefNprog = 3;
  localparam int unsigned DefOffw  = 6;
  localparam int unsigned DefDepth = 4;

endpackage

// File: rtl/ret_stack.sv
// LIFO of return addresses for prog_sequencer. Overflowing pushes and
// underflowing pops are dropped; the caller decides how to flag them.
module ret_stack
  import prog_seq_pkg::*;
#(
  parameter int unsigned Width = DefA,
  parameter int unsigned Depth = DefDepth
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] push_data,
  output logic [Width-1:0] data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned SpW   = $clog2(Depth + 1);
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [SpW-1:0]   sp_q, sp_d;

  assign full  = (sp_q == SpW'(Depth));
  assign empty = (sp_q == '0);
  // Only meaningful when not empty.
  assign data  = mem_q[AddrW'(sp_q - 1'b1)];

  always_comb begin
    sp_d = sp_q;
    if (clear) begin
      sp_d = '0;
    end else if (push && !full) begin
      sp_d = sp_q + 1'b1;
    end else if (pop && !empty) begin
      sp_d = sp_q - 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push && !full && !clear) begin
      mem_q[AddrW'(sp_q)] <= push_data;
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: Start-selected programs with branch/halt control.
// Define PROG_SEQUENCER_RSTACK_EN to add the Call/Ret return stack.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int unsigned A     = DefA,
  parameter int unsigned NPROG = DefNprog,
  parameter int unsigned OFFW  = DefOffw,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     Start,
  input  logic                     Halt,
  input  logic                     BrAbs,
  input  logic                     BrRel,
  input  logic                     Call,
  input  logic                     Ret,
  input  logic                     ALU_flag,
  input  logic [A-1:0]             Target,
  input  logic [OFFW-1:0]          Offset,
  input  logic [NPROG*A-1:0]       StartVec,
  output logic [A-1:0]             ProgCtr,
  output logic [$clog2(NPROG)-1:0] ProgIdx,
  output logic                     Running,
  output logic                     Done,
  output logic                     StackErr
);

  localparam int unsigned IdxW = $clog2(NPROG);

  seq_state_e      state_q, state_d;
  logic            start_q, rise, fall;
  logic [A-1:0]    pc_q, pc_d, pc_inc, pc_rel;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            running_q, done_q;

  assign rise   = Start & ~start_q;
  assign fall   = ~Start & start_q;
  assign pc_inc = pc_q + 1'b1;
  assign pc_rel = pc_q + A'($signed(Offset));

`ifdef PROG_SEQUENCER_RSTACK_EN
  logic         stk_push, stk_pop, stk_clear, stk_full, stk_empty;
  logic         err_set, stack_err_q;
  logic [A-1:0] stk_data;

  ret_stack #(
    .Width (A),
    .Depth (DEPTH)
  ) u_ret_stack (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .clear     (stk_clear),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_inc),
    .data      (stk_data),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  assign stk_clear = (state_d == StArmed) && (state_q != StArmed);
  assign StackErr  = stack_err_q;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      stack_err_q <= 1'b0;
    end else begin
      stack_err_q <= stack_err_q | err_set;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{Call, Ret, DEPTH};
  assign StackErr   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
`ifdef PROG_SEQUENCER_RSTACK_EN
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    err_set  = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (rise) state_d = StArmed;
      end
      StHalted: begin
        if (rise) begin
          state_d = StArmed;
          idx_d   = (idx_q == IdxW'(NPROG - 1)) ? '0 : idx_q + 1'b1;
        end
      end
      StArmed: begin
        if (fall) begin
          pc_d    = StartVec[int'(idx_q)*A +: A];
          state_d = StRun;
        end
      end
      StRun: begin
        if (Halt) begin
          state_d = StHalted;
        end
`ifdef PROG_SEQUENCER_RSTACK_EN
        else if (Ret) begin
          if (stk_empty) begin
            err_set = 1'b1;
            pc_d    = pc_inc;
          end else begin
            stk_pop = 1'b1;
            pc_d    = stk_data;
          end
        end else if (Call) begin
          // A full stack drops the return address but the jump still happens.
          if (stk_full) err_set = 1'b1;
          else          stk_push = 1'b1;
          pc_d = Target;
        end
`endif
        else if (BrAbs && ALU_flag) begin
          pc_d = Target;
        end else if (BrRel && ALU_flag) begin
          pc_d = pc_rel;
        end else begin
          pc_d = pc_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= StIdle;
      start_q   <= 1'b0;
      pc_q      <= '0;
      idx_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= Start;
      pc_q      <= pc_d;
      idx_q     <= idx_d;
      running_q <= (state_d == StRun);
      done_q    <= (state_d == StHalted);
    end
  end

  assign ProgCtr = pc_q;
  assign ProgIdx = idx_q;
  assign Running = running_q;
  assign Done    = done_q;

endmodule
